ahb_lite_cmd_master: RTL and testbench
======================================

Name: ahb_lite_cmd_master

Overview:
- AHB-Lite initiator that turns a valid/ready command stream into single AHB-Lite transfers and returns per-command responses (read data plus an error flag) in issue order.
- Sits between test sequencers or DMA-style engines and the system AHB-Lite fabric: memory model, console, peripherals.
- Pipelined: the next address phase overlaps the current data phase. Honours HREADY wait states and the two-cycle ERROR response.

Parameters:
- RSP_DEPTH, 2, response FIFO entries; power of two, >=2; also caps outstanding transfers.
- HPROT_VAL, 4'b0011, constant driven on HPROT (privileged data access).

Ports:
- HCLK  in  1  bus and block clock.
- HRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle.
- cmd_write  in  1  1=write, 0=read.
- cmd_size  in  3  0=byte, 1=halfword, 2=word; others illegal.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data, right-justified.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data, right-justified, zero-extended; 0 for writes.
- rsp_err  out  1  bus ERROR or misaligned/illegal command.
- HADDR  out  32  AHB address.
- HTRANS  out  2  IDLE(00) or NONSEQ(10) only.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  transfer size.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant HPROT_VAL.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  32  write data, data phase.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer ready.
- HRESP  in  1  error response.

Behaviour:
- Reset (HRESET=1 at posedge HCLK):
  - HTRANS=IDLE, data-phase-valid cleared, FIFO emptied, rsp_valid=0, HWDATA=0.
  - Reset mid-transfer abandons the bus transfer and discards all queued responses.
- Legal command: size 0 any address; size 1 with addr[0]=0; size 2 with addr[1:0]=0. Anything else is illegal.
- Issue condition (combinational) for a legal command: cmd_valid & !err_first & (fifo_count + dphase_valid < RSP_DEPTH).
  - When met: HTRANS=NONSEQ, and HADDR/HWRITE/HSIZE are taken from the command. Otherwise HTRANS=IDLE.
  - HADDR/HWRITE/HSIZE hold the last issued values when IDLE.
- cmd_ready = issue & HREADY, i.e. the address phase completes this edge.
  - Upstream must hold the command stable while cmd_valid=1 and cmd_ready=0.
  - Address outputs therefore stay stable through wait states.
- On address acceptance: register the command into the data-phase slot (write flag, size, addr[1:0], replicated wdata); dphase_valid=1.
- HWDATA is registered and lane-replicated:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Data phase completes on HREADY=1 and pushes one response:
  - rdata: read → lane extracted by addr[1:0]/size, zero-extended; write → 0.
  - err = HRESP.
  - dphase_valid clears unless a new address phase completes on the same edge.
- ERROR handling:
  - First cycle (HRESP=1, HREADY=0): err_first asserts combinationally, HTRANS is forced to IDLE, and the pending command is cancelled (not consumed).
  - Second cycle (HRESP=1, HREADY=1): pushes err=1.
  - The cancelled command is re-issued from the next cycle.
- Illegal command:
  - Consumed without any bus access (cmd_ready=1) only when dphase_valid=0, the FIFO is not full, and the command is not simultaneously issuing.
  - Pushes rsp_err=1, rsp_rdata=0.
  - Response order is always preserved.
- FIFO:
  - Depth RSP_DEPTH, count width log2(RSP_DEPTH)+1, pointers wrap modulo RSP_DEPTH.
  - Simultaneous push and pop when full or empty is legal; count is unchanged.
  - rsp_* show the head entry.
- HREADY=0 with HRESP=0: everything holds, no push.

Test Plan:
- Word write 0xDEADBEEF to 0x100, then read 0x100 with HREADY=1 → two NONSEQ cycles back-to-back; HWDATA=0xDEADBEEF one cycle after first address; responses {err0,0}, {err0,0xDEADBEEF}.
- Byte write 0xA5 to 0x103, then halfword read 0x102 (HRDATA=0xA5001234) → HWDATA=0xA5A5A5A5, HSIZE=0; rsp_rdata=0x0000A500.
- Read with HREADY low 3 cycles while next command pending → HADDR/HTRANS held stable for 3 cycles; cmd_ready=0 until HREADY=1; one response.
- Slave ERROR on write to 0x5000_0000 while read to 0x200 pending → cycle 1 HTRANS=IDLE; rsp_err=1; 0x200 re-issued next cycle; its response follows with err=0.
- Halfword to 0x101 and size=3 command → no NONSEQ; two responses err=1, rdata=0, in order.
- rsp_ready=0, RSP_DEPTH=2, four reads queued → exactly two transfers issued, HTRANS=IDLE afterwards; rsp_ready=1 drains in order and the remaining two then issue.

Source files
------------

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into single pipelined
// AHB-Lite transfers and returns in-order responses through a small FIFO.
module ahb_lite_cmd_master #(
    parameter int         RSP_DEPTH = 2,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_OCC = RSP_DEPTH[CW:0];
    localparam logic [CW-1:0] DEPTH_CNT = RSP_DEPTH[CW-1:0];

    logic          dphase_valid_reg;
    logic          dp_write_reg;
    logic [2:0]    dp_size_reg;
    logic [1:0]    dp_lo_reg;
    logic [31:0]   hwdata_reg;
    logic [31:0]   haddr_reg;
    logic          hwrite_reg;
    logic [2:0]    hsize_reg;
    logic [CW-1:0] count_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [32:0]   fifo_mem [RSP_DEPTH];

    logic          cmd_legal;
    logic          err_first;
    logic          room;
    logic          issue;
    logic          addr_done;
    logic          illegal_take;
    logic          dphase_done;
    logic          push;
    logic          pop;
    logic          push_err;
    logic [31:0]   push_rdata;
    logic [31:0]   rd_extract;
    logic [31:0]   wdata_rep;
    logic [CW:0]   occupancy;
    logic [7:0]    rd_lane [4];

    always_comb begin
        case (cmd_size)
            3'd0:    cmd_legal = 1'b1;
            3'd1:    cmd_legal = ~cmd_addr[0];
            3'd2:    cmd_legal = (cmd_addr[1:0] == 2'b00);
            default: cmd_legal = 1'b0;
        endcase
    end

    // Outstanding transfers (data phase + queued responses) must never exceed the FIFO.
    assign occupancy    = {1'b0, count_reg} + {{CW{1'b0}}, dphase_valid_reg};
    assign room         = occupancy < DEPTH_OCC;
    assign err_first    = dphase_valid_reg & HRESP & ~HREADY;
    assign issue        = cmd_valid & cmd_legal & ~err_first & room;
    assign addr_done    = issue & HREADY;
    assign illegal_take = cmd_valid & ~cmd_legal & ~dphase_valid_reg & (count_reg != DEPTH_CNT);
    assign cmd_ready    = addr_done | illegal_take;
    assign dphase_done  = dphase_valid_reg & HREADY;
    assign push         = dphase_done | illegal_take;
    assign pop          = rsp_valid & rsp_ready;

    assign HTRANS    = issue ? 2'b10 : 2'b00;
    assign HADDR     = issue ? cmd_addr : haddr_reg;
    assign HWRITE    = issue ? cmd_write : hwrite_reg;
    assign HSIZE     = issue ? cmd_size : hsize_reg;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = hwdata_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_lane[gi] = HRDATA[8*gi +: 8];
    end

    always_comb begin
        case (dp_size_reg)
            3'd0:    rd_extract = {24'd0, rd_lane[dp_lo_reg]};
            3'd1:    rd_extract = {16'd0, dp_lo_reg[1] ? HRDATA[31:16] : HRDATA[15:0]};
            default: rd_extract = HRDATA;
        endcase
    end

    always_comb begin
        case (cmd_size)
            3'd0:    wdata_rep = {4{cmd_wdata[7:0]}};
            3'd1:    wdata_rep = {2{cmd_wdata[15:0]}};
            default: wdata_rep = cmd_wdata;
        endcase
    end

    // Illegal commands only ever push when no data phase is live, so one push source at a time.
    assign push_err   = dphase_done ? HRESP : 1'b1;
    assign push_rdata = (dphase_done && !dp_write_reg) ? rd_extract : 32'd0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dphase_valid_reg <= 1'b0;
            dp_write_reg     <= 1'b0;
            dp_size_reg      <= 3'd0;
            dp_lo_reg        <= 2'd0;
            hwdata_reg       <= 32'd0;
            haddr_reg        <= 32'd0;
            hwrite_reg       <= 1'b0;
            hsize_reg        <= 3'd0;
            count_reg        <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
        end else begin
            if (addr_done) begin
                dphase_valid_reg <= 1'b1;
                dp_write_reg     <= cmd_write;
                dp_size_reg      <= cmd_size;
                dp_lo_reg        <= cmd_addr[1:0];
                hwdata_reg       <= wdata_rep;
                haddr_reg        <= cmd_addr;
                hwrite_reg       <= cmd_write;
                hsize_reg        <= cmd_size;
            end else if (dphase_done) begin
                dphase_valid_reg <= 1'b0;
            end
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) fifo_mem[wr_ptr_reg] <= {push_err, push_rdata};
    end

    assign rsp_valid = (count_reg != '0);
    assign {rsp_err, rsp_rdata} = fifo_mem[rd_ptr_reg];
endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Randomized bench for ahb_lite_cmd_master: a byte-array AHB slave with wait states
// and ERROR responses, plus a command-level reference model of the expected responses.
module tb_ahb_lite_cmd_master;
    localparam int DEPTH = 2;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    always #5 HCLK = ~HCLK;

    ahb_lite_cmd_master #(.RSP_DEPTH(DEPTH), .HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct packed { logic write; logic [2:0] size; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
    typedef struct packed { logic err; logic [31:0] rdata; } rsp_t;

    int   n_checks = 0;
    int   n_fail = 0;
    rsp_t exp_q[$];
    cmd_t dir_q[$];
    cmd_t cur;
    bit   have_cmd = 0;
    bit   random_on = 0;
    int   stall_left = 0;
    int   n_pops = 0;
    int   n_wr = 0;
    logic [7:0] bus_mem [256];
    logic [7:0] ref_mem [256];
    logic [31:0] lit_rdata [8];
    logic        lit_err [8];
    logic [31:0] lit_hwdata [3];
    // Slave data-phase state.
    bit          s_active = 0, s_write = 0, s_err = 0, s_err_stage = 0;
    logic [2:0]  s_size = 0;
    logic [31:0] s_addr = 0;
    int          s_wait = 0;
    bit          prev_nonseq_wait = 0, last_valid = 0;
    logic [31:0] prev_haddr = 0, last_addr = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [2:0] size, input logic [31:0] addr);
        return (size == 3'd0) || (size == 3'd1 && addr[0] == 1'b0) ||
               (size == 3'd2 && addr[1:0] == 2'b00);
    endfunction

    // Command-level model: executes each accepted command in order against ref_mem.
    function automatic rsp_t model_exec(input cmd_t c);
        rsp_t r;
        logic [7:0] a;
        r = '0;
        if (!is_legal(c.size, c.addr) || c.addr[31:28] == 4'h5) begin
            r.err = 1'b1;
            return r;
        end
        for (int b = 0; b < (1 << c.size); b++) begin
            a = c.addr[7:0] + 8'(b);
            if (c.write) ref_mem[a] = c.wdata[8*b +: 8];
            else r.rdata[8*b +: 8] = ref_mem[a];
        end
        return r;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.write = 1'($urandom_range(0, 1));
        c.size  = ($urandom_range(0, 99) < 5) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        c.addr  = {24'h0, 8'($urandom())};
        if ($urandom_range(0, 9) != 0) begin
            if (c.size == 3'd1) c.addr[0] = 1'b0;
            if (c.size == 3'd2) c.addr[1:0] = 2'b00;
        end
        if ($urandom_range(0, 99) < 8) c.addr[31:28] = 4'h5;
        c.wdata = $urandom();
        return c;
    endfunction

    task automatic do_reset(input int n);
        @(negedge HCLK);
        HRESET = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (n) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        #1;
        check("reset_htrans", 32'(HTRANS), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_hwdata", HWDATA, 32'd0);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        exp_q.delete();
        s_active = 0; have_cmd = 0; prev_nonseq_wait = 0; last_valid = 0;
        ref_mem = bus_mem;
    endtask

    task automatic step();
        int   occ;
        bit   legal, errf, exp_issue, exp_ready;
        logic [31:0] rd;
        rsp_t r;
        @(negedge HCLK);
        cmd_valid = have_cmd;
        if (have_cmd) begin
            cmd_write = cur.write; cmd_size = cur.size; cmd_addr = cur.addr; cmd_wdata = cur.wdata;
        end else begin
            cmd_write = 1'($urandom_range(0, 1)); cmd_size = 3'($urandom_range(0, 7));
            cmd_addr = $urandom(); cmd_wdata = $urandom();
        end
        if (random_on && stall_left == 0 && $urandom_range(0, 199) == 0) stall_left = 30;
        rsp_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (stall_left > 0) stall_left--;
        rd = $urandom();
        if (!s_active) begin HREADY = 1'b1; HRESP = 1'b0; end
        else if (s_err) begin HREADY = s_err_stage; HRESP = 1'b1; rd = 32'd0; end
        else if (s_wait > 0) begin HREADY = 1'b0; HRESP = 1'b0; end
        else begin
            HREADY = 1'b1; HRESP = 1'b0;
            if (!s_write) for (int l = 0; l < 4; l++) rd[8*l +: 8] = bus_mem[{s_addr[7:2], 2'(l)}];
        end
        HRDATA = rd;
        #1;
        occ = exp_q.size();
        legal = is_legal(cur.size, cur.addr);
        errf = s_active && HRESP && !HREADY;
        exp_issue = have_cmd && legal && !errf && (occ < DEPTH);
        exp_ready = legal ? (exp_issue && HREADY) : (have_cmd && !s_active && occ < DEPTH);
        check("htrans", 32'(HTRANS), exp_issue ? 32'd2 : 32'd0);
        check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'((occ - int'(s_active)) > 0));
        check("consts", {21'd0, HBURST, HPROT, HMASTLOCK}, {21'd0, 3'b000, 4'b0011, 1'b0});
        if (HTRANS == 2'b10) begin
            check("haddr_issue", HADDR, cur.addr);
            check("hctl_issue", {28'd0, HWRITE, HSIZE}, {28'd0, cur.write, cur.size});
        end else if (last_valid) begin
            check("haddr_hold", HADDR, last_addr);
        end
        if (prev_nonseq_wait) check("haddr_wait_stable", HADDR, prev_haddr);
        // Response handshake at this edge.
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            else begin
                r = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, r.rdata);
                check("rsp_err", 32'(rsp_err), 32'(r.err));
                if (n_pops < 8) begin
                    check("lit_rdata", rsp_rdata, lit_rdata[n_pops]);
                    check("lit_err", 32'(rsp_err), 32'(lit_err[n_pops]));
                end
            end
            $display("rsp %0d: rdata=0x%08h err=%0d", n_pops, rsp_rdata, rsp_err);
            n_pops++;
        end
        if (have_cmd && cmd_ready) begin
            exp_q.push_back(model_exec(cur));
            if (legal) begin last_addr = cur.addr; last_valid = 1; end
            have_cmd = 0;
        end
        check("outstanding_cap", 32'(exp_q.size() <= DEPTH), 32'd1);
        // Slave bookkeeping for this edge.
        if (HREADY) begin
            if (s_active && s_write) begin
                if (!s_err)
                    for (int b = 0; b < (1 << s_size); b++)
                        bus_mem[{s_addr[7:2], 2'(int'(s_addr[1:0]) + b)}] = HWDATA[8*(int'(s_addr[1:0]) + b) +: 8];
                if (n_wr < 3) check("lit_hwdata", HWDATA, lit_hwdata[n_wr]);
                n_wr++;
            end
            if (HTRANS == 2'b10) begin
                s_active = 1; s_write = HWRITE; s_size = HSIZE; s_addr = HADDR;
                s_err = (HADDR[31:28] == 4'h5); s_err_stage = 0;
                s_wait = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end else s_active = 0;
        end else begin
            if (s_err) s_err_stage = 1;
            else if (s_wait > 0) s_wait--;
        end
        prev_nonseq_wait = (HTRANS == 2'b10) && !HREADY && !HRESP;
        prev_haddr = HADDR;
        if (!have_cmd) begin
            if (dir_q.size() > 0) begin cur = dir_q.pop_front(); have_cmd = 1; end
            else if (random_on && $urandom_range(0, 9) < 7) begin cur = rand_cmd(); have_cmd = 1; end
        end
    endtask

    initial begin
        int guard;
        HRESET = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_size = 0; cmd_addr = 0; cmd_wdata = 0;
        rsp_ready = 0; HRDATA = 0; HREADY = 1; HRESP = 0;
        for (int i = 0; i < 256; i++) bus_mem[i] = 8'($urandom());
        dir_q.push_back('{1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF});
        dir_q.push_back('{1'b0, 3'd2, 32'h0000_0100, 32'h0});
        dir_q.push_back('{1'b1, 3'd0, 32'h0000_0103, 32'h1234_56A5});
        dir_q.push_back('{1'b0, 3'd1, 32'h0000_0102, 32'h0});
        dir_q.push_back('{1'b0, 3'd1, 32'h0000_0101, 32'h0});
        dir_q.push_back('{1'b1, 3'd3, 32'h0000_0104, 32'h1111_2222});
        dir_q.push_back('{1'b1, 3'd2, 32'h5000_0000, 32'hCAFE_F00D});
        dir_q.push_back('{1'b0, 3'd2, 32'h0000_0100, 32'h0});
        lit_rdata = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0000_A5AD, 32'h0, 32'h0, 32'h0, 32'hA5AD_BEEF};
        lit_err   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        lit_hwdata = '{32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'hCAFE_F00D};
        do_reset(2);
        repeat (80) step();
        check("lit_popped", 32'(n_pops >= 8), 32'd1);
        random_on = 1;
        repeat (1500) step();
        do_reset(2);
        repeat (1500) step();
        random_on = 0; stall_left = 0;
        guard = 0;
        while ((exp_q.size() > 0 || have_cmd) && guard < 300) begin
            step();
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
